// File: rtl/clkdiv_ctrl.sv
// Run-time programmable clock divider: registered divided clock and period strobe,
// with divisor updates and start/stop aligned to output period boundaries.
module clkdiv_ctrl #(
    parameter int CNT_BITS = 8,
    parameter int DIV_RST  = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                cfg_valid_i,
    input  logic [CNT_BITS-1:0] cfg_div_i,
    output logic                cfg_ready_o,
    output logic                cfg_done_o,
    output logic                cfg_err_o,
    output logic                running_o,
    output logic                clk_o,
    output logic                stb_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_BITS-1:0] DIV_INIT = CNT_BITS'(DIV_RST);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS:0]   HALF_ONE = (CNT_BITS+1)'(1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q,   cnt_d;
    logic [CNT_BITS-1:0] div_q,   div_d;
    logic [CNT_BITS-1:0] div_p_q, div_p_d;
    logic                pend_q,  pend_d;
    logic                clk_q,   clk_d;
    logic                stb_q,   stb_d;
    logic                done_q,  done_d;
    logic                err_q,   err_d;

    logic                xfer;
    logic                div_zero;
    logic                period_end;
    logic [CNT_BITS:0]   half_d;

    // Handshake: a divisor moves on any rising edge where cfg_valid_i and
    // cfg_ready_o are both 1; ready drops while a divisor is held for the
    // next boundary, so at most one divisor is ever waiting.
    assign xfer       = cfg_valid_i && !pend_q;
    assign div_zero   = (cfg_div_i == '0);
    assign period_end = (state_q == ST_RUN) && (cnt_q == (div_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        div_p_d = div_p_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (period_end) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_d  = div_p_q;
                        pend_d = 1'b0;
                        done_d = 1'b1;
                    end
                    if (!en_i) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A transfer never coincides with a boundary apply: both need opposite pend_q.
        if (xfer) begin
            if (div_zero) begin
                err_d = 1'b1;
            end else if (state_q == ST_IDLE) begin
                div_d  = cfg_div_i;
                done_d = 1'b1;
            end else begin
                div_p_d = cfg_div_i;
                pend_d  = 1'b1;
            end
        end
    end

    // Outputs are derived from the next-cycle counter and divisor so that
    // the flops present the waveform for the cycle they are entering.
    always_comb begin
        half_d = ({1'b0, div_d} + HALF_ONE) >> 1;
        clk_d  = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_d);
        stb_d  = (state_d == ST_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_INIT;
            div_p_q <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            div_p_q <= div_p_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready_o = !pend_q;
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;
    assign running_o   = (state_q == ST_RUN);
    assign clk_o       = clk_q;
    assign stb_o       = stb_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scenario bench for clkdiv_ctrl: stimulus rows carry the outputs expected after
// the next rising edge; those are queued at drive time and compared one cycle later.
module tb_clkdiv_ctrl;

  localparam int CNT_BITS = 8;
  localparam int DIV_RST  = 2;

  // Output vector order: {running, clk, stb, ready, done, err}
  typedef struct packed {
    logic                en;
    logic                v;
    logic [CNT_BITS-1:0] d;
    logic [5:0]          e;
  } row_t;

  logic                clk_i;
  logic                rst_n_i;
  logic                en_i;
  logic                cfg_valid_i;
  logic [CNT_BITS-1:0] cfg_div_i;
  logic                cfg_ready_o;
  logic                cfg_done_o;
  logic                cfg_err_o;
  logic                running_o;
  logic                clk_o;
  logic                stb_o;

  row_t       stim_q[$];
  logic [5:0] exp_q[$];
  int         tests_run;
  int         tests_failed;

  clkdiv_ctrl #(
    .CNT_BITS(CNT_BITS),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_done_o (cfg_done_o),
    .cfg_err_o  (cfg_err_o),
    .running_o  (running_o),
    .clk_o      (clk_o),
    .stb_o      (stb_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i     = 1'b0;
    en_i        = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_div_i   = '0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    stim_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic add(input logic en, input logic v, input logic [CNT_BITS-1:0] d,
                     input logic [5:0] e);
    row_t r;
    r.en = en;
    r.v  = v;
    r.d  = d;
    r.e  = e;
    stim_q.push_back(r);
  endtask

  task automatic drive(input row_t r);
    @(negedge clk_i);
    en_i        = r.en;
    cfg_valid_i = r.v;
    cfg_div_i   = r.d;
    exp_q.push_back(r.e);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {running_o, clk_o, stb_o, cfg_ready_o, cfg_done_o, cfg_err_o};
  endfunction

  // scenarios
  task automatic test_reset();
    logic [5:0] obs;
    rst_n_i     = 1'b0;
    en_i        = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_div_i   = '0;
    #1;
    obs = outs();
    tests_run++;
    if (obs !== 6'b000100) begin
      tests_failed++;
      $display("FAIL reset: got %b expected %b", obs, 6'b000100);
    end
    do_reset();
    obs = outs();
    tests_run++;
    if (obs !== 6'b000100) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected %b", obs, 6'b000100);
    end
  endtask

  task automatic test_div4();
    row_t r; logic [5:0] obs, e; int i;
    do_reset();
    add(0, 1, 8'd4, 6'b000110);
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 8'd0, 6'b111100);
      add(1, 0, 8'd0, 6'b110100);
      add(1, 0, 8'd0, 6'b100100);
      add(1, 0, 8'd0, 6'b100100);
    end
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL div4 step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_div1_div3();
    row_t r; logic [5:0] obs, e; int i;
    do_reset();
    add(0, 1, 8'd1, 6'b000110);
    for (int k = 0; k < 4; k++) add(1, 0, 8'd0, 6'b111100);
    add(1, 1, 8'd3, 6'b111000);
    add(1, 0, 8'd0, 6'b111110);
    add(1, 0, 8'd0, 6'b110100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 0, 8'd0, 6'b110100);
    add(1, 0, 8'd0, 6'b100100);
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL div1_div3 step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_reconfig_mid();
    row_t r; logic [5:0] obs, e; int i;
    do_reset();
    add(0, 1, 8'd4, 6'b000110);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 0, 8'd0, 6'b110100);
    add(1, 1, 8'd6, 6'b100000);
    add(1, 1, 8'd9, 6'b100000);
    add(1, 0, 8'd0, 6'b111110);
    add(1, 0, 8'd0, 6'b110100);
    add(1, 0, 8'd0, 6'b110100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b111100);
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL reconfig_mid step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_period_end_and_err();
    row_t r; logic [5:0] obs, e; int i;
    do_reset();
    add(0, 1, 8'd4, 6'b000110);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 0, 8'd0, 6'b110100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 1, 8'd2, 6'b111000);
    add(1, 0, 8'd0, 6'b110000);
    add(1, 0, 8'd0, 6'b100000);
    add(1, 0, 8'd0, 6'b100000);
    add(1, 0, 8'd0, 6'b111110);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 1, 8'd0, 6'b100101);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 0, 8'd0, 6'b100100);
    add(0, 1, 8'd0, 6'b000101);
    add(0, 0, 8'd0, 6'b000100);
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL period_end_err step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_stop_restart();
    row_t r; logic [5:0] obs, e; int i;
    do_reset();
    add(0, 1, 8'd8, 6'b000110);
    add(1, 0, 8'd0, 6'b111100);
    for (int k = 0; k < 3; k++) add(0, 0, 8'd0, 6'b110100);
    for (int k = 0; k < 4; k++) add(0, 0, 8'd0, 6'b100100);
    add(0, 0, 8'd0, 6'b000100);
    add(0, 0, 8'd0, 6'b000100);
    add(1, 0, 8'd0, 6'b111100);
    for (int k = 0; k < 3; k++) add(1, 0, 8'd0, 6'b110100);
    for (int k = 0; k < 4; k++) add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b111100);
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL stop_restart step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    row_t r; logic [5:0] obs, e; int i;
    do_reset();
    add(0, 1, 8'd4, 6'b000110);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 1, 8'd7, 6'b110000);
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL async_pre step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    obs = outs();
    tests_run++;
    if (obs !== 6'b000100) begin
      tests_failed++;
      $display("FAIL async_reset: got %b expected %b", obs, 6'b000100);
    end
    @(negedge clk_i);
    en_i        = 1'b0;
    cfg_valid_i = 1'b0;
    rst_n_i     = 1'b1;
    // divisor must be back at DIV_RST=2 with nothing pending
    add(1, 0, 8'd0, 6'b111100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b111100);
    add(1, 0, 8'd0, 6'b100100);
    add(1, 0, 8'd0, 6'b111100);
    i = 0;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      drive(r);
      obs = outs();
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL async_post step %0d: got %b expected %b", i, obs, e);
      end
      i++;
    end
  endtask

  // sequence and final report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_div4();
    test_div1_div3();
    test_reconfig_mid();
    test_period_end_and_err();
    test_stop_restart();
    test_async_reset();
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
